// File: rtl/sd_wb_sel_pkg.sv
// ============================================================================
// Module      : sd_wb_sel_pkg
// Description : Shared constants and lane mapping for the Wishbone byte-select
//               generator. Lane order follows SD_WB_SEL_LITTLE_ENDIAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_wb_sel_pkg;

  localparam int         BLKSIZE_W_DEFAULT = 12;
  localparam logic [3:0] SEL_ALL           = 4'hf;

  // Maps byte offset k within a word to its wbm_sel_o bit.
  function automatic logic [1:0] lane_bit(input logic [1:0] k);
`ifdef SD_WB_SEL_LITTLE_ENDIAN_EN
    return k;
`else
    return 2'd3 - k;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_wb_sel_lane.sv
// ============================================================================
// Module      : sd_wb_sel_lane
// Description : Range test for one byte lane: base_q <= addr < end_q (33-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_wb_sel_lane (
  input  logic [32:0] base_q,
  input  logic [32:0] end_q,
  input  logic [32:0] addr,
  output logic        in_range
);

  assign in_range = (addr >= base_q) && (addr < end_q);

endmodule

`default_nettype wire

// File: rtl/sd_wb_sel_ctrl.sv
// ============================================================================
// Module      : sd_wb_sel_ctrl
// Description : Registered Wishbone byte-lane select for the SD DMA master.
//               Masks partial first/last words of [base, base+xfersize).
//               Optional macro SD_WB_SEL_LITTLE_ENDIAN_EN selects lane order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_wb_sel_ctrl
  import sd_wb_sel_pkg::*;
#(
  parameter int BLKSIZE_W = BLKSIZE_W_DEFAULT
) (
  input  logic                 wb_clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [31:0]          base_adr_i,
  input  logic [31:0]          wbm_adr_i,
  input  logic [BLKSIZE_W-1:0] xfersize,
  output logic [3:0]           wbm_sel_o
);

  logic [31:0] base_q;
  logic [32:0] end_q;
  logic [32:0] word_adr;
  logic [3:0]  lane_in;
  logic [3:0]  lane_mask;

  assign word_adr = {1'b0, wbm_adr_i[31:2], 2'b00};

  for (genvar k = 0; k < 4; k++) begin : g_lane
    sd_wb_sel_lane u_lane (
      .base_q   ({1'b0, base_q}),
      .end_q    (end_q),
      .addr     (word_adr + 33'(k)),
      .in_range (lane_in[k])
    );
  end

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < 4; k++) begin
      lane_mask[lane_bit(2'(k))] = lane_in[k];
    end
  end

  // Parameters track the inputs whenever idle so the first active edge uses them.
  always_ff @(posedge wb_clk) begin
    if (!rst) begin
      base_q    <= '0;
      end_q     <= '0;
      wbm_sel_o <= SEL_ALL;
    end else if (!ena) begin
      base_q    <= base_adr_i;
      end_q     <= {1'b0, base_adr_i} + 33'(xfersize);
      wbm_sel_o <= SEL_ALL;
    end else begin
      wbm_sel_o <= (|lane_in) ? lane_mask : SEL_ALL;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_wb_sel_ctrl.sv
// Self-checking bench for sd_wb_sel_ctrl: directed literals plus random traffic
// compared every cycle against a byte-range model.
`timescale 1ns/1ps
`default_nettype none

module tb_sd_wb_sel_ctrl;

`ifdef SD_WB_SEL_LITTLE_ENDIAN_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif

  logic        wb_clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] base_adr_i = '0;
  logic [31:0] wbm_adr_i = '0;
  logic [11:0] xfersize = '0;
  logic [3:0]  wbm_sel_o;

  always #5 wb_clk = ~wb_clk;

  sd_wb_sel_ctrl #(.BLKSIZE_W(12)) dut (
    .wb_clk     (wb_clk),
    .rst        (rst),
    .ena        (ena),
    .base_adr_i (base_adr_i),
    .wbm_adr_i  (wbm_adr_i),
    .xfersize   (xfersize),
    .wbm_sel_o  (wbm_sel_o)
  );

  longint     m_base = 0;
  longint     m_end = 0;
  logic [3:0] exp_sel = 4'hf;
  bit         model_valid = 1'b0;

  bit         lit_en = 1'b0;
  logic [3:0] lit_val = 4'hf;
  string      lit_name = "";
  bit         cur_lit_en = 1'b0;
  logic [3:0] cur_lit_val = 4'hf;
  string      cur_lit_name = "";

  int tests = 0;
  int fails = 0;

  // Which bytes of the word fall in [b, e); lanes placed by endianness.
  function automatic logic [3:0] model_sel(input longint b, input longint e,
                                           input logic en, input logic [31:0] adr);
    longint     w;
    longint     byte_a;
    logic [3:0] m;
    bit         any;
    w   = {32'd0, adr[31:2], 2'b00};
    m   = 4'h0;
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      byte_a = w + k;
      if (byte_a >= b && byte_a < e) begin
        any = 1'b1;
        if (LE) m[k] = 1'b1;
        else    m[3-k] = 1'b1;
      end
    end
    return (!en || !any) ? 4'hf : m;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  always @(posedge wb_clk) begin
    cur_lit_en   = lit_en;
    cur_lit_val  = lit_val;
    cur_lit_name = lit_name;
    if (!rst) begin
      exp_sel = 4'hf;
      m_base  = 0;
      m_end   = 0;
    end else begin
      exp_sel = model_sel(m_base, m_end, ena, wbm_adr_i);
      if (!ena) begin
        m_base = {32'd0, base_adr_i};
        m_end  = m_base + {52'd0, xfersize};
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge wb_clk) begin
    if (model_valid) begin
      tests++;
      if (wbm_sel_o !== exp_sel) begin
        fails++;
        $display("FAIL model_cmp t=%0t adr=%h sel=%h expected %h", $time, wbm_adr_i, wbm_sel_o, exp_sel);
      end
      if (cur_lit_en) begin
        tests++;
        if (wbm_sel_o !== cur_lit_val) begin
          fails++;
          $display("FAIL %s: sel=%h expected %h", cur_lit_name, wbm_sel_o, cur_lit_val);
        end
        tests++;
        if (exp_sel !== cur_lit_val) begin
          fails++;
          $display("FAIL model_pin_%s: model=%h expected %h", cur_lit_name, exp_sel, cur_lit_val);
        end
      end
    end
  end

  // Literal values are written big-endian and mirrored for the little-endian build.
  task automatic drive(input logic r, input logic e, input logic [31:0] b,
                       input logic [11:0] s, input logic [31:0] a,
                       input bit chk, input logic [3:0] v, input string nm);
    @(negedge wb_clk);
    rst        = r;
    ena        = e;
    base_adr_i = b;
    xfersize   = s;
    wbm_adr_i  = a;
    lit_en     = chk;
    lit_val    = LE ? rev4(v) : v;
    lit_name   = nm;
  endtask

  task automatic capture(input logic [31:0] b, input logic [11:0] s);
    drive(1'b1, 1'b0, b, s, 32'd0, 1'b0, 4'hf, "");
  endtask

  logic [31:0] rb;
  logic [31:0] rbase;
  logic [11:0] rsize;

  initial begin
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 4'hf, "");
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 4'hf, "");
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0, 0, 0, 1'b1, 4'hf, "idle");

    capture(4, 1);
    drive(1'b1, 1'b1, 4, 1, 4, 1'b1, 4'h8, "b4s1_w4");
    drive(1'b1, 1'b1, 4, 1, 8, 1'b1, 4'hf, "b4s1_w8");
    drive(1'b1, 1'b0, 4, 1, 8, 1'b1, 4'hf, "b4s1_enalow");
    capture(1, 1);
    drive(1'b1, 1'b1, 1, 1, 0, 1'b1, 4'h4, "b1s1_w0");

    capture(11, 2);
    drive(1'b1, 1'b1, 11, 2, 8,  1'b1, 4'h1, "b11s2_w8");
    drive(1'b1, 1'b1, 11, 2, 13, 1'b1, 4'h8, "b11s2_w12");
    drive(1'b1, 1'b1, 11, 2, 16, 1'b1, 4'hf, "b11s2_w16");
    capture(42, 4);
    drive(1'b1, 1'b1, 42, 4, 40, 1'b1, 4'h3, "b42s4_w40");
    drive(1'b1, 1'b1, 42, 4, 44, 1'b1, 4'hc, "b42s4_w44");
    drive(1'b1, 1'b1, 42, 4, 48, 1'b1, 4'hf, "b42s4_w48");

    capture(52, 5);
    drive(1'b1, 1'b1, 52, 5, 52, 1'b1, 4'hf, "b52s5_w52");
    drive(1'b1, 1'b1, 52, 5, 56, 1'b1, 4'h8, "b52s5_w56");
    drive(1'b1, 1'b1, 52, 5, 60, 1'b1, 4'hf, "b52s5_w60");
    capture(85, 8);
    drive(1'b1, 1'b1, 85, 8, 84, 1'b1, 4'h7, "b85s8_w84");
    drive(1'b1, 1'b1, 85, 8, 88, 1'b1, 4'hf, "b85s8_w88");
    drive(1'b1, 1'b1, 85, 8, 92, 1'b1, 4'h8, "b85s8_w92");
    drive(1'b1, 1'b1, 85, 8, 96, 1'b1, 4'hf, "b85s8_w96");
    capture(100, 19);
    drive(1'b1, 1'b1, 100, 19, 116, 1'b1, 4'he, "b100s19_w116");

    capture(8, 0);
    drive(1'b1, 1'b1, 8, 0, 8, 1'b1, 4'hf, "size0_w8");
    drive(1'b1, 1'b1, 8, 0, 4, 1'b1, 4'hf, "size0_w4");

    capture(11, 2);
    drive(1'b1, 1'b1, 200, 50, 8,  1'b1, 4'h1, "hold_w8");
    drive(1'b1, 1'b1, 0,   0,  12, 1'b1, 4'h8, "hold_w12");

    capture(42, 4);
    drive(1'b1, 1'b1, 42, 4, 40, 1'b1, 4'h3, "pre_rst_w40");
    drive(1'b0, 1'b1, 42, 4, 44, 1'b1, 4'hf, "rst_mid");
    drive(1'b1, 1'b1, 42, 4, 44, 1'b1, 4'hf, "post_rst_nocap");

    rb = 0;
    for (int i = 0; i < 800; i++) begin
      rsize = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 24));
      rbase = ($urandom_range(0, 7) == 0) ? 32'hFFFF_F000 + $urandom_range(0, 4095)
                                          : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        rb = rbase;
        drive(($urandom_range(0, 31) != 0), 1'b0, rbase, rsize, 32'($urandom), 1'b0, 4'hf, "");
      end else begin
        drive(($urandom_range(0, 31) != 0), 1'b1, rbase, rsize,
              rb + 32'($urandom_range(0, 64)) - 32'd16, 1'b0, 4'hf, "");
      end
    end

    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 4'hf, "");
    @(posedge wb_clk);
    @(negedge wb_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
